writeback_commit_queue: RTL

Parametrised write-back stage with a commit queue: accepts MEM-stage results via valid/ready, forms the result (ALU / load with alignment and sign-extension / PC+4 / immediate), buffers up to DEPTH results, and commits them in order to the register file under a downstream handshake. It sits between the memory/cache stage and the register-file write port. It lets a register-file arbiter stall commits without stalling the cache controller. It also provides youngest-match forwarding from the queued entries and a retired-instruction counter.

---
 rtl/writeback_commit_queue.sv | 133 +++++++++++++
 1 files changed

// File: rtl/writeback_commit_queue.sv
// Write-back stage: formats MEM-stage results, buffers them in an in-order commit queue,
// and exposes youngest-match forwarding plus a retired-instruction counter.
module writeback_commit_queue #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_regwrite,
  input  logic [1:0]         in_resultsrc,
  input  logic [2:0]         in_funct3,
  input  logic [XLEN-1:0]    in_aluresult,
  input  logic [XLEN-1:0]    in_readdata,
  input  logic [XLEN-1:0]    in_pc_plus4,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  input  logic [RADDR_W-1:0] fwd_rd,
  output logic               fwd_hit,
  output logic [XLEN-1:0]    fwd_data,
  output logic [CNT_W-1:0]   retire_count
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned OFFW = $clog2(XLEN / 8);

  logic [XLEN-1:0]    q_result [DEPTH];
  logic [RADDR_W-1:0] q_rd     [DEPTH];
  logic               q_we     [DEPTH];
  logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CNT_W-1:0]   retire_q;

  logic               push, pop;
  logic [OFFW-1:0]    off, half_off, word_off;
  logic [XLEN-1:0]    byte_lane, half_lane, word_lane;
  logic [XLEN-1:0]    load_data, result;
  logic [PW-1:0]      fwd_idx;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^in_aluresult[XLEN-1:OFFW];

  // Lane selection: halfword/word accesses drop the offset bits below their size.
  always_comb begin
    off       = in_aluresult[OFFW-1:0];
    half_off  = off & ~OFFW'(1);
    word_off  = off & ~OFFW'(3);
    byte_lane = in_readdata >> {off, 3'b000};
    half_lane = in_readdata >> {half_off, 3'b000};
    word_lane = in_readdata >> {word_off, 3'b000};
    unique case (in_funct3)
      3'b000:  load_data = XLEN'($signed(byte_lane[7:0]));
      3'b100:  load_data = XLEN'(byte_lane[7:0]);
      3'b001:  load_data = XLEN'($signed(half_lane[15:0]));
      3'b101:  load_data = XLEN'(half_lane[15:0]);
      3'b010:  load_data = XLEN'($signed(word_lane[31:0]));
      3'b110:  load_data = (XLEN == 64) ? XLEN'(word_lane[31:0]) : in_readdata;
      default: load_data = in_readdata;
    endcase
  end

  always_comb begin
    unique case (in_resultsrc)
      2'b00:   result = in_aluresult;
      2'b01:   result = load_data;
      2'b10:   result = in_pc_plus4;
      default: result = in_imm;
    endcase
  end

  assign in_ready     = (count_q < CW'(DEPTH));
  assign out_valid    = (count_q != '0);
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign rf_we        = pop & q_we[rd_ptr_q];
  assign rf_waddr     = q_rd[rd_ptr_q];
  assign rf_wdata     = q_result[rd_ptr_q];
  assign retire_count = retire_q;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && q_we[fwd_idx] && (q_rd[fwd_idx] == fwd_rd) && (fwd_rd != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_result[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      retire_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_result[i] <= '0;
        q_rd[i]     <= '0;
        q_we[i]     <= 1'b0;
      end
    end else begin
      if (push) begin
        q_result[wr_ptr_q] <= result;
        q_rd[wr_ptr_q]     <= in_rd;
        q_we[wr_ptr_q]     <= in_regwrite && (in_rd != '0);
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        retire_q <= retire_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
